// File: rtl/dc_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dc_sweep_pkg
// Brief    : Shared types and defaults for the DC sweep sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package dc_sweep_pkg;

    localparam int CODE_W_DEFAULT     = 16;
    localparam int SETTLE_CYC_DEFAULT = 64;
    localparam int SETTLE_CNT_W       = 16;
    localparam int IDX_W              = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CONVERT = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } sweep_state_e;

    // Index of the final point of a loop with n points.
    function automatic logic [IDX_W-1:0] last_index(input int n);
        return IDX_W'(n - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : settle_timer
// Brief    : Loadable down-counter; expire is high while the count equals 1.
// Revision : 1.0 - initial release
// ============================================================================
module settle_timer
    import dc_sweep_pkg::*;
#(
    parameter int CNT_W = SETTLE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Loaded with N, the count spends exactly N cycles before leaving 1.
    assign expire = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/dc_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dc_sweep_sequencer
// Brief    : Nested Vgs/Vds DAC sweep with settle, ADC capture and result stream.
// Revision : 1.0 - initial release
// ============================================================================
module dc_sweep_sequencer
    import dc_sweep_pkg::*;
#(
    parameter int                CODE_W     = CODE_W_DEFAULT,
    parameter logic [CODE_W-1:0] VGS_START  = CODE_W'(16'h8000),
    parameter logic [CODE_W-1:0] VGS_STEP   = CODE_W'(16'h0100),
    parameter int                VGS_N      = 8,
    parameter logic [CODE_W-1:0] VDS_START  = CODE_W'(16'h0000),
    parameter logic [CODE_W-1:0] VDS_STEP   = CODE_W'(16'h0200),
    parameter int                VDS_N      = 16,
    parameter int                SETTLE_CYC = SETTLE_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] vgs_code,
    output logic [CODE_W-1:0] vds_code,
    output logic              adc_req,
    input  logic              adc_ack,
    input  logic [CODE_W-1:0] adc_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_vgs,
    output logic [CODE_W-1:0] out_vds,
    output logic [CODE_W-1:0] out_id
);

    localparam logic [IDX_W-1:0]        c_vgs_last    = last_index(VGS_N);
    localparam logic [IDX_W-1:0]        c_vds_last    = last_index(VDS_N);
    localparam logic [SETTLE_CNT_W-1:0] c_settle_load = SETTLE_CNT_W'(SETTLE_CYC);

    sweep_state_e      r_state,     w_state_nxt;
    logic [CODE_W-1:0] r_vgs_code,  w_vgs_code_nxt;
    logic [CODE_W-1:0] r_vds_code,  w_vds_code_nxt;
    logic [IDX_W-1:0]  r_vgs_idx,   w_vgs_idx_nxt;
    logic [IDX_W-1:0]  r_vds_idx,   w_vds_idx_nxt;
    logic              r_adc_req,   w_adc_req_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic [CODE_W-1:0] r_out_vgs,   w_out_vgs_nxt;
    logic [CODE_W-1:0] r_out_vds,   w_out_vds_nxt;
    logic [CODE_W-1:0] r_out_id,    w_out_id_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              w_timer_load;
    logic              w_settle_expire;
    logic              w_vgs_last;
    logic              w_vds_last;

    settle_timer #(
        .CNT_W (SETTLE_CNT_W)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_timer_load),
        .value  (c_settle_load),
        .expire (w_settle_expire)
    );

    assign w_vgs_last = (r_vgs_idx == c_vgs_last);
    assign w_vds_last = (r_vds_idx == c_vds_last);

    always_comb begin
        w_state_nxt     = r_state;
        w_vgs_code_nxt  = r_vgs_code;
        w_vds_code_nxt  = r_vds_code;
        w_vgs_idx_nxt   = r_vgs_idx;
        w_vds_idx_nxt   = r_vds_idx;
        w_adc_req_nxt   = r_adc_req;
        w_out_valid_nxt = r_out_valid;
        w_out_vgs_nxt   = r_out_vgs;
        w_out_vds_nxt   = r_out_vds;
        w_out_id_nxt    = r_out_id;
        w_done_nxt      = 1'b0;
        w_timer_load    = 1'b0;

        // Abort wins over ack and handshake; a record accepted now still counts.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt     = ST_IDLE;
            w_adc_req_nxt   = 1'b0;
            w_out_valid_nxt = 1'b0;
            w_vgs_code_nxt  = VGS_START;
            w_vds_code_nxt  = VDS_START;
            w_vgs_idx_nxt   = '0;
            w_vds_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_vgs_code_nxt = VGS_START;
                        w_vds_code_nxt = VDS_START;
                        w_vgs_idx_nxt  = '0;
                        w_vds_idx_nxt  = '0;
                        w_timer_load   = 1'b1;
                        w_state_nxt    = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_settle_expire) begin
                        w_adc_req_nxt = 1'b1;
                        w_state_nxt   = ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (adc_ack) begin
                        w_adc_req_nxt   = 1'b0;
                        w_out_valid_nxt = 1'b1;
                        w_out_vgs_nxt   = r_vgs_code;
                        w_out_vds_nxt   = r_vds_code;
                        w_out_id_nxt    = adc_data;
                        w_state_nxt     = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        if (w_vds_last && w_vgs_last) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else if (w_vds_last) begin
                            w_vds_idx_nxt  = '0;
                            w_vds_code_nxt = VDS_START;
                            w_vgs_idx_nxt  = r_vgs_idx + IDX_W'(1);
                            w_vgs_code_nxt = r_vgs_code + VGS_STEP;
                            w_timer_load   = 1'b1;
                            w_state_nxt    = ST_SETTLE;
                        end else begin
                            w_vds_idx_nxt  = r_vds_idx + IDX_W'(1);
                            w_vds_code_nxt = r_vds_code + VDS_STEP;
                            w_timer_load   = 1'b1;
                            w_state_nxt    = ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_vgs_code  <= VGS_START;
            r_vds_code  <= VDS_START;
            r_vgs_idx   <= '0;
            r_vds_idx   <= '0;
            r_adc_req   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_vgs   <= '0;
            r_out_vds   <= '0;
            r_out_id    <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_vgs_code  <= w_vgs_code_nxt;
            r_vds_code  <= w_vds_code_nxt;
            r_vgs_idx   <= w_vgs_idx_nxt;
            r_vds_idx   <= w_vds_idx_nxt;
            r_adc_req   <= w_adc_req_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_vgs   <= w_out_vgs_nxt;
            r_out_vds   <= w_out_vds_nxt;
            r_out_id    <= w_out_id_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign vgs_code  = r_vgs_code;
    assign vds_code  = r_vds_code;
    assign adc_req   = r_adc_req;
    assign out_valid = r_out_valid;
    assign out_vgs   = r_out_vgs;
    assign out_vds   = r_out_vds;
    assign out_id    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_dc_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_sweep_sequencer
// Brief    : Randomised bench for dc_sweep_sequencer against a nested-loop model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_sweep_sequencer;

    localparam int          P_CODE_W    = 16;
    localparam logic [15:0] P_VGS_START = 16'h8000;
    localparam logic [15:0] P_VGS_STEP  = 16'h0100;
    localparam int          P_VGS_N     = 2;
    localparam logic [15:0] P_VDS_START = 16'hFF00;
    localparam logic [15:0] P_VDS_STEP  = 16'h0100;
    localparam int          P_VDS_N     = 3;
    localparam int          P_SETTLE    = 3;
    localparam int          N_REC       = P_VGS_N * P_VDS_N;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, adc_ack, out_ready;
    logic [15:0] adc_data;
    logic        busy, done, adc_req, out_valid;
    logic [15:0] vgs_code, vds_code, out_vgs, out_vds, out_id;

    dc_sweep_sequencer #(
        .CODE_W     (P_CODE_W),
        .VGS_START  (P_VGS_START),
        .VGS_STEP   (P_VGS_STEP),
        .VGS_N      (P_VGS_N),
        .VDS_START  (P_VDS_START),
        .VDS_STEP   (P_VDS_STEP),
        .VDS_N      (P_VDS_N),
        .SETTLE_CYC (P_SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .vgs_code  (vgs_code),
        .vds_code  (vds_code),
        .adc_req   (adc_req),
        .adc_ack   (adc_ack),
        .adc_data  (adc_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vgs   (out_vgs),
        .out_vds   (out_vds),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int          cycles = 0;
    int          ack_delay = 2;
    int          req_age = 0;
    int          ready_mode = 0;
    int          abort_at = -1;
    int          acks_total = 0;
    bit          stray_en = 0;
    bit          busy_start_en = 0;
    bit          start_pulse = 0;
    bit          abort_fired = 0;
    bit          ack_prev = 0;
    int          done_cnt = 0;
    int          av_bad = 0;
    int          last_change = 0;
    logic        prev_busy = 1'b0;
    logic        prev_req = 1'b0;
    logic [15:0] prev_vgs = '0;
    logic [15:0] prev_vds = '0;
    logic [47:0] got_q[$];
    logic [15:0] id_q[$];
    int          lat_q[$];

    // Expected k-th record: Vds loops fastest, codes wrap at 16 bits.
    function automatic logic [47:0] exp_rec(input int k);
        int          g;
        int          d;
        logic [15:0] v;
        logic [15:0] w;
        logic [15:0] id;
        g  = k / P_VDS_N;
        d  = k % P_VDS_N;
        v  = 16'(int'(P_VGS_START) + g * int'(P_VGS_STEP));
        w  = 16'(int'(P_VDS_START) + d * int'(P_VDS_STEP));
        id = (k < id_q.size()) ? id_q[k] : 16'hxxxx;
        return {v, w, id};
    endfunction

    task automatic clear_run();
        got_q.delete();
        id_q.delete();
        lat_q.delete();
        done_cnt    = 0;
        av_bad      = 0;
        abort_fired = 0;
        abort_at    = -1;
        acks_total  = 0;
        ack_prev    = 0;
    endtask

    // One cycle: observe post-edge outputs, then drive the next edge's inputs.
    task automatic tick();
        @(negedge clk);
        cycles++;
        if (done === 1'b1) done_cnt++;
        if (ack_prev && out_valid !== 1'b1) av_bad++;
        if (busy && !prev_busy) last_change = cycles;
        else if (busy && (vgs_code !== prev_vgs || vds_code !== prev_vds)) last_change = cycles;
        if (adc_req && !prev_req) lat_q.push_back(cycles - last_change);
        prev_busy = busy;
        prev_req  = adc_req;
        prev_vgs  = vgs_code;
        prev_vds  = vds_code;

        start       = start_pulse || (busy_start_en && busy && ($urandom_range(0, 2) == 0));
        start_pulse = 0;
        abort       = 1'b0;
        adc_ack     = 1'b0;
        ack_prev    = 0;
        if (adc_req) begin
            req_age++;
            if (req_age >= ack_delay) begin
                adc_ack  = 1'b1;
                adc_data = 16'($urandom);
                req_age  = 0;
                if (abort_at == acks_total) begin
                    abort       = 1'b1;
                    abort_fired = 1;
                end else begin
                    id_q.push_back(adc_data);
                    ack_prev = 1;
                end
                acks_total++;
            end
        end else begin
            req_age = 0;
            if (stray_en && ($urandom_range(0, 3) == 0)) begin
                adc_ack  = 1'b1;
                adc_data = 16'($urandom);
            end
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        if (out_valid && out_ready) got_q.push_back({out_vgs, out_vds, out_id});
    endtask

    task automatic run_sweep(output bit ok);
        start_pulse = 1;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
        ok = (done_cnt > 0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (adc_req !== 1'b0) $display("FAIL reset_adc_req got=%b exp=0", adc_req); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (vgs_code !== P_VGS_START) $display("FAIL reset_vgs got=%h exp=%h", vgs_code, P_VGS_START); else n_pass++;
        n_checks++; if (vds_code !== P_VDS_START) $display("FAIL reset_vds got=%h exp=%h", vds_code, P_VDS_START); else n_pass++;
        n_checks++; if ({out_vgs, out_vds, out_id} !== 48'h0) $display("FAIL reset_out_rec got=%h exp=0", {out_vgs, out_vds, out_id}); else n_pass++;
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_min_sweep();
        bit ok;
        clear_run();
        ack_delay  = 2;
        ready_mode = 0;
        run_sweep(ok);
        n_checks++; if (!ok) $display("FAIL min_timeout got=no_done exp=done"); else n_pass++;
        n_checks++; if (got_q.size() != N_REC) $display("FAIL min_count got=%0d exp=%0d", got_q.size(), N_REC); else n_pass++;
        for (int k = 0; k < got_q.size() && k < N_REC; k++) begin
            n_checks++;
            if (got_q[k] !== exp_rec(k)) $display("FAIL min_rec%0d got=%h exp=%h", k, got_q[k], exp_rec(k));
            else n_pass++;
        end
        if (got_q.size() >= 3) begin
            n_checks++;
            if ({got_q[0][31:16], got_q[1][31:16], got_q[2][31:16]} !== 48'hFF00_0000_0100)
                $display("FAIL wrap_vds got=%h,%h,%h exp=ff00,0000,0100", got_q[0][31:16], got_q[1][31:16], got_q[2][31:16]);
            else n_pass++;
        end
        n_checks++; if (done_cnt != 1) $display("FAIL min_done_pulses got=%0d exp=1", done_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL min_busy_end got=%b exp=0", busy); else n_pass++;
        n_checks++; if (lat_q.size() != N_REC) $display("FAIL min_req_count got=%0d exp=%0d", lat_q.size(), N_REC); else n_pass++;
        foreach (lat_q[i]) begin
            n_checks++;
            if (lat_q[i] != P_SETTLE) $display("FAIL min_settle_lat%0d got=%0d exp=%0d", i, lat_q[i], P_SETTLE);
            else n_pass++;
        end
        n_checks++; if (av_bad != 0) $display("FAIL min_ack_to_valid got=%0d late exp=0", av_bad); else n_pass++;
    endtask

    task automatic test_random_sweeps();
        bit ok;
        for (int it = 0; it < 3; it++) begin
            clear_run();
            ack_delay  = int'($urandom_range(0, 4));
            ready_mode = 1;
            run_sweep(ok);
            n_checks++; if (!ok) $display("FAIL rnd%0d_timeout got=no_done exp=done", it); else n_pass++;
            n_checks++; if (got_q.size() != N_REC) $display("FAIL rnd%0d_count got=%0d exp=%0d", it, got_q.size(), N_REC); else n_pass++;
            for (int k = 0; k < got_q.size() && k < N_REC; k++) begin
                n_checks++;
                if (got_q[k] !== exp_rec(k)) $display("FAIL rnd%0d_rec%0d got=%h exp=%h", it, k, got_q[k], exp_rec(k));
                else n_pass++;
            end
            n_checks++; if (done_cnt != 1) $display("FAIL rnd%0d_done got=%0d exp=1", it, done_cnt); else n_pass++;
            n_checks++; if (av_bad != 0) $display("FAIL rnd%0d_ack_to_valid got=%0d exp=0", it, av_bad); else n_pass++;
        end
        ready_mode = 0;
    endtask

    task automatic test_backpressure();
        logic [47:0] hold;
        int          bp_bad;
        bit          seen;
        clear_run();
        ack_delay   = 1;
        ready_mode  = 2;
        start_pulse = 1;
        seen        = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = (out_valid === 1'b1);
        end
        n_checks++; if (!seen) $display("FAIL bp_valid_timeout got=no_valid exp=valid"); else n_pass++;
        hold   = {out_vgs, out_vds, out_id};
        bp_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({out_vgs, out_vds, out_id} !== hold || out_valid !== 1'b1 || adc_req !== 1'b0) bp_bad++;
        end
        n_checks++; if (bp_bad != 0) $display("FAIL bp_hold got=%0d unstable cycles exp=0", bp_bad); else n_pass++;
        n_checks++; if (got_q.size() != 0) $display("FAIL bp_no_xfer got=%0d exp=0", got_q.size()); else n_pass++;
        ready_mode = 0;
        tick();
        n_checks++; if (got_q.size() != 1) $display("FAIL bp_one_xfer got=%0d exp=1", got_q.size()); else n_pass++;
        n_checks++; if (hold !== exp_rec(0)) $display("FAIL bp_rec0 got=%h exp=%h", hold, exp_rec(0)); else n_pass++;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
        tick();
        n_checks++; if (got_q.size() != N_REC) $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), N_REC); else n_pass++;
        for (int k = 0; k < got_q.size() && k < N_REC; k++) begin
            n_checks++;
            if (got_q[k] !== exp_rec(k)) $display("FAIL bp_rec%0d got=%h exp=%h", k, got_q[k], exp_rec(k));
            else n_pass++;
        end
    endtask

    task automatic test_abort_on_ack();
        int vbad;
        clear_run();
        ack_delay   = 2;
        ready_mode  = 0;
        abort_at    = 2;
        start_pulse = 1;
        for (int i = 0; i < 300 && !abort_fired; i++) tick();
        n_checks++; if (!abort_fired) $display("FAIL abort_timeout got=no_abort exp=abort"); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (adc_req !== 1'b0 || out_valid !== 1'b0) $display("FAIL abort_req_valid got=%b%b exp=00", adc_req, out_valid); else n_pass++;
        n_checks++; if ({vgs_code, vds_code} !== {P_VGS_START, P_VDS_START}) $display("FAIL abort_codes got=%h/%h exp=%h/%h", vgs_code, vds_code, P_VGS_START, P_VDS_START); else n_pass++;
        vbad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) vbad++;
        end
        n_checks++; if (vbad != 0) $display("FAIL abort_stays_idle got=%0d bad cycles exp=0", vbad); else n_pass++;
        n_checks++; if (got_q.size() != 2) $display("FAIL abort_records got=%0d exp=2", got_q.size()); else n_pass++;
        n_checks++; if (done_cnt != 0) $display("FAIL abort_done got=%0d exp=0", done_cnt); else n_pass++;
        abort_at = -1;
    endtask

    task automatic test_reset_mid_sweep();
        bit ok;
        bit in_settle;
        clear_run();
        ack_delay   = 1;
        ready_mode  = 0;
        start_pulse = 1;
        in_settle   = 0;
        for (int i = 0; i < 300 && !in_settle; i++) begin
            tick();
            in_settle = (got_q.size() >= 1) && busy && !adc_req && !out_valid;
        end
        n_checks++; if (!in_settle) $display("FAIL rstmid_reach_settle got=no exp=yes"); else n_pass++;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || adc_req !== 1'b0) $display("FAIL rstmid_ctrl got=%b%b%b exp=000", busy, out_valid, adc_req); else n_pass++;
        n_checks++; if ({out_vgs, out_vds, out_id} !== 48'h0) $display("FAIL rstmid_out got=%h exp=0", {out_vgs, out_vds, out_id}); else n_pass++;
        n_checks++; if ({vgs_code, vds_code} !== {P_VGS_START, P_VDS_START}) $display("FAIL rstmid_codes got=%h/%h exp=%h/%h", vgs_code, vds_code, P_VGS_START, P_VDS_START); else n_pass++;
        rst_n = 1'b1;
        tick();
        clear_run();
        run_sweep(ok);
        n_checks++; if (!ok) $display("FAIL rstmid_timeout got=no_done exp=done"); else n_pass++;
        n_checks++; if (got_q.size() != N_REC) $display("FAIL rstmid_count got=%0d exp=%0d", got_q.size(), N_REC); else n_pass++;
        for (int k = 0; k < got_q.size() && k < N_REC; k++) begin
            n_checks++;
            if (got_q[k] !== exp_rec(k)) $display("FAIL rstmid_rec%0d got=%h exp=%h", k, got_q[k], exp_rec(k));
            else n_pass++;
        end
    endtask

    task automatic test_start_busy_stray_ack();
        bit ok;
        int lbad;
        clear_run();
        ack_delay     = 1;
        ready_mode    = 0;
        stray_en      = 1;
        busy_start_en = 1;
        run_sweep(ok);
        stray_en      = 0;
        busy_start_en = 0;
        n_checks++; if (!ok) $display("FAIL stray_timeout got=no_done exp=done"); else n_pass++;
        n_checks++; if (got_q.size() != N_REC) $display("FAIL stray_count got=%0d exp=%0d", got_q.size(), N_REC); else n_pass++;
        for (int k = 0; k < got_q.size() && k < N_REC; k++) begin
            n_checks++;
            if (got_q[k] !== exp_rec(k)) $display("FAIL stray_rec%0d got=%h exp=%h", k, got_q[k], exp_rec(k));
            else n_pass++;
        end
        lbad = 0;
        foreach (lat_q[i]) if (lat_q[i] != P_SETTLE) lbad++;
        n_checks++; if (lbad != 0 || lat_q.size() != N_REC) $display("FAIL stray_timing got=%0d bad of %0d exp=0 of %0d", lbad, lat_q.size(), N_REC); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL stray_done got=%0d exp=1", done_cnt); else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        adc_ack   = 1'b0;
        adc_data  = '0;
        out_ready = 1'b0;
        test_reset();
        test_min_sweep();
        test_random_sweeps();
        test_backpressure();
        test_abort_on_ack();
        test_reset_mid_sweep();
        test_start_busy_stray_ack();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dc_sweep_sequencer.md
DC_SWEEP_SEQUENCER -- requirements
Module: dc_sweep_sequencer

Interface
REQ-001 Parameter CODE_W, default 16: width of DAC codes and the ADC sample.
REQ-002 Parameter VGS_START, default 16'h8000: first gate-source code.
REQ-003 Parameter VGS_STEP, default 16'h0100: gate code increment, two's-complement.
REQ-004 Parameter VGS_N, default 8: number of gate points (outer loop), 1..256.
REQ-005 Parameter VDS_START, default 16'h0000: first drain-source code.
REQ-006 Parameter VDS_STEP, default 16'h0200: drain code increment, two's-complement.
REQ-007 Parameter VDS_N, default 16: number of drain points (inner loop), 1..256.
REQ-008 Parameter SETTLE_CYC, default 64: settle wait after each code change, 1..65535 cycles.
REQ-009 Port clk, input, 1: single clock, all logic on its rising edge.
REQ-010 Port rst_n, input, 1: synchronous, active-low reset.
REQ-011 Ports: start (in, 1) launches a sweep; abort (in, 1) cancels it; busy (out, 1) high while sweeping; done (out, 1) one-cycle pulse at completion.
REQ-012 Ports: vgs_code, vds_code (out, CODE_W) drive the source DACs.
REQ-013 Ports: adc_req (out, 1) requests a conversion; adc_ack (in, 1) marks a conversion complete; adc_data (in, CODE_W) is the drain-current sample, valid with adc_ack.
REQ-014 Ports: out_valid (out, 1) and out_ready (in, 1) handshake the result stream; out_vgs, out_vds, out_id (out, CODE_W) carry the result record.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, CONVERT, EMIT and DONE.
REQ-016 IDLE: when start=1, the block SHALL load vgs_code=VGS_START, vds_code=VDS_START and both point indices = 0, load the settle counter with SETTLE_CYC, and go to SETTLE.
REQ-017 SETTLE: the counter SHALL decrement once per cycle; on the cycle it reaches 1 the block SHALL go to CONVERT, so the dwell is exactly SETTLE_CYC cycles.
REQ-018 CONVERT: adc_req SHALL be 1 from CONVERT entry until the cycle adc_ack=1; adc_data SHALL be captured on that cycle, and the next state SHALL be EMIT.
REQ-019 adc_ack seen outside CONVERT SHALL be ignored.
REQ-020 EMIT: out_valid SHALL be 1 and out_vgs/out_vds/out_id SHALL hold stable until out_valid & out_ready are both 1 in the same cycle.
REQ-021 Once a record transfers, the inner index SHALL advance and vds_code SHALL add VDS_STEP (wrapping modulo 2^CODE_W), then return to SETTLE with a reload.
REQ-022 When the inner index is VDS_N-1, the inner index and vds_code SHALL reset to 0 and VDS_START instead, the outer index SHALL advance, and vgs_code SHALL add VGS_STEP (also wrapping modulo 2^CODE_W).
REQ-023 When both indices are at their last point, the transfer SHALL go to DONE; DONE SHALL assert done for one cycle and then return to IDLE.
REQ-024 Exactly VGS_N*VDS_N records SHALL be emitted per sweep, in the order Vds-fastest.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 start SHALL be ignored while busy.
REQ-027 abort=1 in any non-IDLE state SHALL go to IDLE next cycle: out_valid and adc_req drop, done is not pulsed, and the codes return to VGS_START/VDS_START.
REQ-028 Abort SHALL take priority over ack and handshake in the same cycle; a record transferring in that cycle is still considered delivered.
REQ-029 Output latency from the code change to the ADC request SHALL be SETTLE_CYC cycles; from adc_ack to out_valid SHALL be 1 cycle.

Reset
REQ-030 With rst_n=0 at a clock edge: state=IDLE, busy=0, done=0, adc_req=0, out_valid=0, vgs_code=VGS_START, vds_code=VDS_START, out_vgs/out_vds/out_id=0, all counters 0.
REQ-031 Reset mid-sweep SHALL behave as abort with all outputs at their reset values, and no partial record SHALL remain pending.

Structure
REQ-032 The state enum and the defaults for CODE_W and SETTLE_CYC SHALL live in the shared package dc_sweep_pkg.
REQ-033 The settle counter SHALL be the separate sub-module settle_timer, with ports load, value, expire.
REQ-034 All remaining logic SHALL be in one FSM process plus registered outputs; there SHALL be no combinational path from input to output except out_valid not depending on out_ready.

Verification
REQ-035 Minimal sweep: VGS_N=2, VDS_N=2, SETTLE_CYC=3, adc_ack 2 cycles after adc_req, out_ready held 1 -> 4 records (8000,0000),(8000,0200),(8100,0000),(8100,0200), then done pulses once and busy falls.
REQ-036 Backpressure: out_ready=0 for 10 cycles during EMIT -> record held stable, no adc_req, and only one transfer once ready rises.
REQ-037 Abort in CONVERT on the same cycle as adc_ack -> IDLE next cycle, no record emitted, no done pulse, codes at START values.
REQ-038 Wrap: VDS_START=FF00, VDS_STEP=0100, VDS_N=3 -> vds sequence FF00, 0000, 0100.
REQ-039 Reset in SETTLE, then start 2 cycles after release -> a full fresh sweep from index 0, with the record count equal to VGS_N*VDS_N.
REQ-040 start while busy and a stray adc_ack in SETTLE -> no effect on sequence, timing, or record count.
